// File: rtl/letter_display_scanner.sv
// Multiplexed 2-digit-per-letter 7-segment scanner with a frame-synchronised valid/ready letter input.
// Optional build macro: LEADING_ZERO_BLANK_EN (blank a tens digit of 0).
module letter_display_scanner #(
    parameter int CHANNELS = 2,
    parameter int DIVIDER  = 100000,
    parameter int VAL_W    = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*VAL_W-1:0] letters,
    output logic [6:0]                seg,
    output logic [2*CHANNELS-1:0]     an,
    output logic                      frame_done
);
    localparam int ND     = 2 * CHANNELS;
    localparam int TICK_W = (DIVIDER > 1) ? $clog2(DIVIDER) : 1;
    localparam int DIG_W  = (ND > 1) ? $clog2(ND) : 1;

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready.
    // in_ready is low from a capture until the next frame boundary applies it.

    logic [TICK_W-1:0]         tick_q, tick_d;
    logic [DIG_W-1:0]          d_q, d_d;
    logic                      pending_q;
    logic [CHANNELS*VAL_W-1:0] shadow_q;
    logic [CHANNELS*VAL_W-1:0] display_q;
    logic [6:0]                seg_q;
    logic [ND-1:0]             an_q;
    logic                      frame_done_q;

    logic                      step;
    logic                      boundary;
    logic                      transfer;
    logic [VAL_W-1:0]          cur_val;
    logic [VAL_W-1:0]          tens_v;
    logic [VAL_W-1:0]          ones_v;
    logic [3:0]                digit;
    logic [6:0]                seg_next;
    logic [ND-1:0]             an_next;

    always_comb begin
        step     = (tick_q == TICK_W'(DIVIDER - 1));
        tick_d   = step ? '0 : tick_q + 1'b1;
        boundary = step && (d_q == DIG_W'(ND - 1));
        d_d      = d_q;
        if (step) begin
            d_d = boundary ? '0 : d_q + 1'b1;
        end
        transfer = in_valid && !pending_q;
    end

    // Digit d shows channel d/2: ones on even d, tens on odd d.
    always_comb begin
        cur_val = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if ((int'(d_q) >> 1) == c) begin
                cur_val = display_q[c*VAL_W +: VAL_W];
            end
        end
        tens_v = cur_val / VAL_W'(10);
        ones_v = cur_val % VAL_W'(10);
        digit  = d_q[0] ? tens_v[3:0] : ones_v[3:0];

        case (digit)
            4'd0:    seg_next = 7'b1000000;
            4'd1:    seg_next = 7'b1111001;
            4'd2:    seg_next = 7'b0100100;
            4'd3:    seg_next = 7'b0110000;
            4'd4:    seg_next = 7'b0011001;
            4'd5:    seg_next = 7'b0010010;
            4'd6:    seg_next = 7'b0000010;
            4'd7:    seg_next = 7'b1111000;
            4'd8:    seg_next = 7'b0000000;
            4'd9:    seg_next = 7'b0010000;
            default: seg_next = 7'h7F;
        endcase
`ifdef LEADING_ZERO_BLANK_EN
        if (d_q[0] && (tens_v == '0)) begin
            seg_next = 7'h7F;
        end
`else
`endif
        if (int'(cur_val) > 26) begin
            seg_next = 7'b0111111;
        end
        an_next = ~(ND'(1) << d_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q       <= '0;
            d_q          <= '0;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            display_q    <= '0;
            seg_q        <= 7'h7F;
            an_q         <= '1;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            d_q          <= d_d;
            frame_done_q <= boundary;
            if (step) begin
                seg_q <= seg_next;
                an_q  <= an_next;
            end
            // A capture coinciding with a boundary waits for the following boundary.
            if (boundary && pending_q) begin
                display_q <= shadow_q;
                pending_q <= 1'b0;
            end else if (transfer) begin
                shadow_q  <= letters;
                pending_q <= 1'b1;
            end
        end
    end

    assign in_ready   = !pending_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_letter_display_scanner.sv
// Bench for letter_display_scanner with CHANNELS=2, DIVIDER=4.
module tb_letter_display_scanner;
    localparam int CH  = 2;
    localparam int DIV = 4;
    localparam int VW  = 5;
    localparam int ND  = 2 * CH;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [CH*VW-1:0]  letters;
    logic [6:0]        seg;
    logic [ND-1:0]     an;
    logic              frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [ND+6:0] exp_q[$];

    letter_display_scanner #(.CHANNELS(CH), .DIVIDER(DIV), .VAL_W(VW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .letters    (letters),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] glyph(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] model_seg(input logic [CH*VW-1:0] lt, input int dg);
        int v;
        logic [VW-1:0] raw;
        raw = lt[(dg/2)*VW +: VW];
        v = int'(raw);
        if (v > 26) return 7'b0111111;
        if (dg % 2 == 1) begin
`ifdef LEADING_ZERO_BLANK_EN
            if (v / 10 == 0) return 7'h7F;
`endif
            return glyph(v / 10);
        end
        return glyph(v % 10);
    endfunction

    task automatic push_frame(input logic [CH*VW-1:0] lt);
        logic [ND-1:0] a;
        for (int d = 0; d < ND; d++) begin
            a = ~(ND'(1) << d);
            exp_q.push_back({a, model_seg(lt, d)});
        end
    endtask

    task automatic scan_digits(input int n, input string name);
        logic [ND-1:0] prev;
        logic [ND+6:0] exp;
        int cnt;
        for (int i = 0; i < n; i++) begin
            prev = an;
            cnt = 0;
            do begin
                @(negedge clk);
                cnt++;
            end while (an == prev && cnt < 3*DIV);
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            n_cmp++;
            if (an == prev) begin
                n_err++;
                $display("FAIL %s digit %0d: anode stuck at %b, required %b", name, i, an, exp[ND+6:7]);
            end else if ({an, seg} !== exp) begin
                n_err++;
                $display("FAIL %s digit %0d: an=%b seg=%b, required an=%b seg=%b",
                         name, i, an, seg, exp[ND+6:7], exp[6:0]);
            end
        end
    endtask

    task automatic send(input logic [CH*VW-1:0] lt, input string name);
        int cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL %s ready_wait: in_ready=%b, required 1", name, in_ready);
        end
        in_valid = 1'b1;
        letters  = lt;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL %s pending_after_transfer: in_ready=%b, required 0", name, in_ready);
        end
    endtask

    task automatic wait_apply(input string name);
        int cnt = 0;
        while (!in_ready && cnt < 3*ND*DIV) begin
            @(negedge clk);
            cnt++;
        end
        n_cmp++;
        if (in_ready !== 1'b1 || frame_done !== 1'b1) begin
            n_err++;
            $display("FAIL %s apply: in_ready=%b frame_done=%b, required 1 1", name, in_ready, frame_done);
        end
    endtask

    task automatic check_blank(input string name);
        n_cmp++;
        if (seg !== 7'h7F || an !== '1 || in_ready !== 1'b1 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL %s: seg=%h an=%b in_ready=%b frame_done=%b, required 7f %b 1 0",
                     name, seg, an, in_ready, frame_done, {ND{1'b1}});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        letters = '0;
        repeat (3) @(negedge clk);
        check_blank("reset_state");
        rst_n = 1'b1;
        push_frame('0);
        scan_digits(ND, "reset_first_frame");
    endtask

    task automatic test_basic();
        logic [CH*VW-1:0] lt = {5'd23, 5'd7};
        send(lt, "basic");
        wait_apply("basic");
        push_frame(lt);
        scan_digits(ND, "basic_frame");
    endtask

    task automatic test_back_to_back();
        logic [CH*VW-1:0] a = {5'd19, 5'd26};
        logic [CH*VW-1:0] b = {5'd1, 5'd10};
        int t0, t1;
        int cnt = 0;
        @(negedge clk);
        while (!in_ready && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        in_valid = 1'b1;
        letters  = a;
        @(negedge clk);
        letters  = b;
        wait_apply("b2b_first");
        t0 = cyc;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_second_capture: in_ready=%b, required 0", in_ready);
        end
        push_frame(a);
        scan_digits(ND, "b2b_first_frame");
        wait_apply("b2b_second");
        t1 = cyc;
        n_cmp++;
        if (t1 - t0 != ND*DIV) begin
            n_err++;
            $display("FAIL b2b_frame_period: %0d cycles, required %0d", t1 - t0, ND*DIV);
        end
        push_frame(b);
        scan_digits(ND, "b2b_second_frame");
    endtask

    task automatic test_out_of_range();
        logic [CH*VW-1:0] lt = {5'd30, 5'd12};
        send(lt, "out_of_range");
        wait_apply("out_of_range");
        push_frame(lt);
        scan_digits(ND, "out_of_range_frame");
    endtask

    task automatic test_leading_zero();
        logic [CH*VW-1:0] lt = {5'd26, 5'd4};
        send(lt, "leading_zero");
        wait_apply("leading_zero");
        push_frame(lt);
        scan_digits(ND, "leading_zero_frame");
    endtask

    task automatic test_random();
        logic [CH*VW-1:0] lt;
        for (int i = 0; i < 4; i++) begin
            for (int c = 0; c < CH; c++) lt[c*VW +: VW] = VW'($urandom_range(0, 31));
            send(lt, "random");
            wait_apply("random");
            push_frame(lt);
            scan_digits(ND, "random_frame");
        end
    endtask

    task automatic test_reset_mid();
        send({5'd8, 5'd9}, "reset_mid");
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_blank("reset_mid_blank");
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_mid_pending: in_ready=%b, required 1", in_ready);
        end
        push_frame('0);
        push_frame('0);
        scan_digits(2*ND, "reset_mid_frames");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_out_of_range();
        test_leading_zero();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
